// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one memory request at a
// time, applies branch/jump redirects and hands instructions to decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  input  logic        branch,
  input  logic        equal,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  input  logic        out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_drop;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_instr;

  logic        w_redir;
  logic [31:0] w_tgt;

  // Jump outranks a taken branch; targets are forced word aligned.
  assign w_redir = jump | (branch & equal);
  assign w_tgt   = (jump ? jump_target : branch_target) & 32'hFFFF_FFFC;

  assign ireq_valid = (r_state == S_REQ);
  assign ireq_addr  = r_pc & 32'hFFFF_FFFC;
  assign out_valid  = (r_state == S_HOLD);
  assign out_pc     = r_out_pc;
  assign out_instr  = r_out_instr;

  // Fetch FSM: a redirect preempts every other transition in every state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_drop      <= 1'b0;
      r_out_pc    <= RESET_PC;
      r_out_instr <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          if (w_redir) r_pc <= w_tgt;
        end
        S_REQ: begin
          if (w_redir) begin
            r_pc <= w_tgt;
            // An accepted request now targets the old path; its response is stale.
            if (ireq_ready) begin
              r_drop  <= 1'b1;
              r_state <= S_WAIT;
            end
          end else if (ireq_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_redir) begin
            r_pc <= w_tgt;
            if (iresp_valid) begin
              // Data arriving with the redirect belongs to the old path.
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_drop <= 1'b1;
            end
          end else if (iresp_valid) begin
            if (r_drop) begin
              r_drop  <= 1'b0;
              r_state <= S_REQ;
            end else begin
              r_out_instr <= iresp_data;
              r_out_pc    <= r_pc;
              r_state     <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (w_redir) begin
            // Held instruction is on the wrong path, even if decode takes it now.
            r_pc    <= w_tgt;
            r_state <= S_REQ;
          end else if (out_ready) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized phase, checked
// by a scoreboard of expected (pc, instr) deliveries in program order.
module tb_fetch_ctrl;

  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;
  logic        branch, equal, jump;
  logic [31:0] branch_target, jump_target;
  logic        out_valid;
  logic [31:0] out_pc, out_instr;
  logic        out_ready;

  fetch_ctrl #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_ready(ireq_ready),
    .iresp_valid(iresp_valid), .iresp_data(iresp_data),
    .branch(branch), .equal(equal), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int ndeliv = 0;

  // memory model state
  bit          outst = 0;
  int          cnt = 0;
  logic [31:0] maddr = 32'h0;
  int          lat_min = 1, lat_max = 1;
  int          rdy_pct = 100;
  bit          rnd = 0;

  // instruction memory contents: a bijection of the address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic expect_from(input logic [31:0] t);
    exp_t e;
    e.pc    = t & 32'hFFFF_FFFC;
    e.instr = memf(e.pc);
    q.delete();
    q.push_back(e);
  endtask

  // Drive decode's redirect inputs; an effective redirect restarts the expected stream.
  task automatic drive_redir(input logic j, input logic [31:0] jt,
                             input logic b, input logic e, input logic [31:0] bt);
    jump = j; jump_target = jt; branch = b; equal = e; branch_target = bt;
    if (j) expect_from(jt);
    else if (b && e) expect_from(bt);
  endtask

  task automatic clr_redir();
    jump = 0; branch = 0; equal = 0;
  endtask

  function automatic logic [31:0] rtgt();
    if ($urandom_range(3, 0) == 0) return 32'hFFFF_FFFC | 32'($urandom_range(3, 0));
    return $urandom;
  endfunction

  // One clock: sample at the falling edge, update memory model and inputs after the rise.
  task automatic tick();
    logic acc, got;
    logic [31:0] a;
    int r;
    @(negedge clk);
    acc = reset && ireq_valid && ireq_ready;
    a   = ireq_addr;
    got = iresp_valid && outst;
    @(posedge clk); #1;
    if (got) outst = 0;
    if (acc) begin
      outst = 1; maddr = a;
      cnt = int'($urandom_range(lat_max, lat_min)) - 1;
    end else if (outst && cnt > 0) cnt--;
    iresp_valid = outst && (cnt == 0);
    iresp_data  = outst ? memf(maddr) : 32'h0;
    if (rnd) begin
      if (!outst && $urandom_range(7, 0) == 0) begin
        iresp_valid = 1; iresp_data = $urandom;
      end
      ireq_ready = ($urandom_range(99, 0) < rdy_pct);
      out_ready  = ($urandom_range(3, 0) != 0);
      r = int'($urandom_range(15, 0));
      case (r)
        0: drive_redir(1, rtgt(), 0, 0, rtgt());
        1: drive_redir(0, rtgt(), 1, 1, rtgt());
        2: drive_redir(0, rtgt(), 1, 0, rtgt());
        3: drive_redir(1, rtgt(), 1, 1, rtgt());
        default: drive_redir(0, rtgt(), 0, 1'($urandom_range(1, 0)), rtgt());
      endcase
    end
  endtask

  task automatic bench_reset();
    outst = 0; cnt = 0;
    iresp_valid = 0; iresp_data = 0;
    clr_redir();
    expect_from(RPC);
  endtask

  // Monitor: pops the scoreboard on every consumed instruction and checks protocol rules.
  logic        prev_hold = 0;
  logic [31:0] ph_pc, ph_instr;
  always @(negedge clk) begin
    logic redir;
    exp_t e, n;
    if (!reset) prev_hold = 0;
    else begin
      redir = jump | (branch & equal);
      if (prev_hold) begin
        chk1("hold_valid", out_valid, 1'b1);
        chk("hold_pc", out_pc, ph_pc);
        chk("hold_instr", out_instr, ph_instr);
      end
      if (outst) chk1("no_req_while_waiting", ireq_valid, 1'b0);
      if (ireq_valid) begin
        chk("addr_align", {30'd0, ireq_addr[1:0]}, 32'd0);
        chk1("req_excl_out", out_valid, 1'b0);
      end
      if (out_valid && out_ready && !redir) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_empty actual=pc %h required=no delivery", out_pc);
        end else begin
          total--;
          e = q.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
          n.pc = e.pc + 32'd4; n.instr = memf(n.pc);
          q.push_back(n);
          ndeliv++;
        end
      end
      prev_hold = out_valid && !out_ready && !redir;
      ph_pc = out_pc; ph_instr = out_instr;
    end
  end

  initial begin
    reset = 0; ireq_ready = 1; out_ready = 1;
    branch_target = 0; jump_target = 0;
    bench_reset();
    tick(); tick();
    chk1("rst_ireq_valid", ireq_valid, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_ireq_addr", ireq_addr, RPC);
    chk("rst_out_pc", out_pc, RPC);
    chk("rst_out_instr", out_instr, 32'h0);

    // straight-line fetch, 1-cycle memory
    reset = 1;
    chk1("idle_no_req", ireq_valid, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk1("seq_req_valid", ireq_valid, 1'b1);
      chk("seq_req_addr", ireq_addr, RPC + 32'(4 * i));
      tick();
      chk1("seq_wait_no_out", out_valid, 1'b0);
      tick();
      chk1("seq_out_valid", out_valid, 1'b1);
      chk("seq_out_pc", out_pc, RPC + 32'(4 * i));
      tick();
    end

    // backpressure
    out_ready = 0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk1("bp_out_valid", out_valid, 1'b1);
      chk("bp_out_pc", out_pc, RPC + 32'hC);
      chk1("bp_no_req", ireq_valid, 1'b0);
      tick();
    end
    out_ready = 1;
    tick();
    chk("bp_next_addr", ireq_addr, RPC + 32'h10);

    // jump while waiting; stale response two cycles later is dropped
    lat_min = 3; lat_max = 3;
    tick();
    drive_redir(1, 32'h0040_0103, 0, 0, 32'h0);
    tick(); clr_redir();
    chk1("wr_no_out0", out_valid, 1'b0);
    tick();
    chk1("wr_resp_arrives", iresp_valid, 1'b1);
    chk1("wr_no_out1", out_valid, 1'b0);
    tick();
    chk1("wr_no_out2", out_valid, 1'b0);
    chk1("wr_req_valid", ireq_valid, 1'b1);
    chk("wr_req_addr", ireq_addr, 32'h0040_0100);
    lat_min = 1; lat_max = 1;
    tick(); tick();
    chk("wr_out_pc", out_pc, 32'h0040_0100);

    // jump and taken branch together in hold with out_ready=1
    drive_redir(1, 32'h0000_2004, 1, 1, 32'h0000_1000);
    tick(); clr_redir();
    chk("both_req_addr", ireq_addr, 32'h0000_2004);
    tick(); tick();
    chk("both_out_pc", out_pc, 32'h0000_2004);
    out_ready = 0;
    drive_redir(0, 32'h0, 1, 0, 32'h0000_3000);
    tick();
    chk1("nt_still_hold", out_valid, 1'b1);
    chk("nt_out_pc", out_pc, 32'h0000_2004);
    clr_redir(); out_ready = 1;
    tick();
    chk("nt_next_addr", ireq_addr, 32'h0000_2008);

    // request accepted in the same cycle as a redirect
    drive_redir(1, 32'h0050_0000, 0, 0, 32'h0);
    tick(); clr_redir();
    chk1("acc_no_out", out_valid, 1'b0);
    tick();
    chk1("acc_req_valid", ireq_valid, 1'b1);
    chk("acc_req_addr", ireq_addr, 32'h0050_0000);
    tick(); tick();
    chk("acc_out_pc", out_pc, 32'h0050_0000);

    // wrap past the top of the address space
    drive_redir(1, 32'hFFFF_FFFE, 0, 0, 32'h0);
    tick(); clr_redir();
    chk("wrap_req_addr", ireq_addr, 32'hFFFF_FFFC);
    tick(); tick();
    chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_next_addr", ireq_addr, 32'h0);

    // asynchronous reset mid-wait
    lat_min = 4; lat_max = 4;
    tick();
    #2 reset = 0;
    #1;
    chk1("ar_ireq_valid", ireq_valid, 1'b0);
    chk1("ar_out_valid", out_valid, 1'b0);
    chk("ar_ireq_addr", ireq_addr, RPC);
    bench_reset();
    lat_min = 1; lat_max = 1;
    tick(); tick();
    reset = 1;
    tick();
    chk1("ar_restart_valid", ireq_valid, 1'b1);
    chk("ar_restart_addr", ireq_addr, RPC);
    tick(); tick();
    chk("ar_restart_pc", out_pc, RPC);

    // randomized traffic
    rnd = 1; rdy_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) tick();
    rnd = 0;
    clr_redir(); out_ready = 1; ireq_ready = 1;
    for (int i = 0; i < 20; i++) tick();
    chk1("random_progress", ndeliv > 100, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
